// File: rtl/aes_uart_tx_ctrl_pkg.sv
// Shared definitions for the AES block-to-UART byte streamer.
//   state_e     : controller FSM states
//   SYNC_BYTE   : framing byte sent ahead of each block when AES_UART_SYNC_EN is defined
//   DEF_*       : default parameter values used by aes_uart_tx_ctrl
package aes_uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        GAP,
        FIN
    } state_e;

    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

    localparam int unsigned DEF_NBYTES  = 16;
    localparam int unsigned DEF_GAP_CYC = 8;
    localparam int unsigned DEF_TMO_CYC = 1023;

endpackage

// File: rtl/aes_uart_tx_gapcnt.sv
// Loadable down-counter shared by the inter-byte gap and the uart_done timeout.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i this cycle (has priority over counting)
//   load_val_i    : value to load
//   zero_o        : counter currently holds zero
// The counter decrements every cycle until it reaches zero and then holds there.
module aes_uart_tx_gapcnt #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_uart_tx_ctrl.sv
// Streams an accepted AES block, MSB byte first, to a byte-wide UART transmitter.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   blk_valid/blk_data/blk_ready : block handshake; the block is copied on acceptance
//   uart_en/uart_din : one-cycle start strobe and byte to the transmitter
//   uart_done/tx_flag : transmitter byte-finished pulse and busy level
//   busy, blk_done : block in progress, one-cycle end-of-block pulse
//   tmo_err/err_clr : sticky uart_done timeout flag and its clear (set wins)
// Build option: define AES_UART_SYNC_EN to precede every block with SYNC_BYTE.
module aes_uart_tx_ctrl
    import aes_uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES  = DEF_NBYTES,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC,
    parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                blk_valid,
    input  logic [8*NBYTES-1:0] blk_data,
    output logic                blk_ready,
    output logic                uart_en,
    output logic [7:0]          uart_din,
    input  logic                uart_done,
    input  logic                tx_flag,
    output logic                busy,
    output logic                blk_done,
    output logic                tmo_err,
    input  logic                err_clr
);

`ifdef AES_UART_SYNC_EN
    localparam int unsigned NTOT = NBYTES + 1;
`else
    localparam int unsigned NTOT = NBYTES;
`endif
    localparam int unsigned SRW  = 8 * NTOT;
    localparam int unsigned BCW  = $clog2(NTOT + 1);
    localparam int unsigned CMAX = (GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC;
    localparam int unsigned CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
    // Counters are loaded with N-1 so that the state lasts exactly N cycles.
    localparam logic [CW-1:0] GAP_LD = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CW-1:0] TMO_LD = CW'(TMO_CYC - 1);

    state_e         state_q, state_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           tmo_q, tmo_d;
    logic           rdy_en_q;
    logic [SRW-1:0] blk_load;
    logic           cnt_load;
    logic [CW-1:0]  cnt_val;
    logic           cnt_zero;

`ifdef AES_UART_SYNC_EN
    assign blk_load = {SYNC_BYTE, blk_data};
`else
    assign blk_load = blk_data;
`endif

    aes_uart_tx_gapcnt #(
        .W (CW)
    ) u_gapcnt (
        .clk_i      (sys_clk),
        .rst_ni     (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        tmo_d    = tmo_q;
        cnt_load = 1'b0;
        cnt_val  = TMO_LD;
        if (err_clr) begin
            tmo_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (blk_valid && blk_ready) begin
                    sr_d    = blk_load;
                    bcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Arm the timeout so it starts counting on the first WAIT cycle.
                cnt_load = 1'b1;
                cnt_val  = TMO_LD;
                state_d  = WAIT;
            end
            WAIT: begin
                // uart_done is tested first so it wins over a coincident timeout.
                if (uart_done) begin
                    sr_d   = sr_q << 8;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BCW'(NTOT - 1)) begin
                        state_d = FIN;
                    end else if (GAP_CYC == 0) begin
                        state_d = SEND;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LD;
                        state_d  = GAP;
                    end
                end else if (cnt_zero) begin
                    tmo_d   = 1'b1;
                    sr_d    = '0;
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = SEND;
                end
            end
            FIN: begin
                bcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bcnt_q   <= '0;
            tmo_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            tmo_q    <= tmo_d;
            rdy_en_q <= 1'b1;
        end
    end

    // rdy_en_q keeps blk_ready low until the first edge after reset release.
    assign blk_ready = rdy_en_q && (state_q == IDLE) && !tx_flag;
    assign uart_en   = (state_q == SEND);
    assign uart_din  = sr_q[SRW-1 -: 8];
    assign busy      = (state_q != IDLE);
    assign blk_done  = (state_q == FIN);
    assign tmo_err   = tmo_q;

endmodule
